// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand/result handshake bundle for nibble_serial_adder.
// The optional out_ovf signal is present only when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
  );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide ripple-carry adder that sums one 4-bit nibble per
// clock, carrying between nibbles through a registered carry flop.
// Optional feature macro: NIBBLE_SERIAL_ADDER_OVF_EN adds a two's-complement
// overflow flag (out_ovf) reported alongside out_cout.
// All outputs come straight from flops; operands are captured on accept so the
// upstream side may change them freely while the sum is being built.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input logic                clk,
  input logic                rst,
  nibble_serial_adder_if.slave bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     sum_reg;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [W-1:0]     out_sum_reg;
  logic             out_cout_reg;
  logic             busy_reg;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       nib;
  logic [W-1:0]     sum_next;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             out_ovf_reg;
  logic [3:0]       low3;
  logic             ovf_next;
`endif

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sum   = out_sum_reg;
  assign bus.out_cout  = out_cout_reg;
  assign bus.busy      = busy_reg;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign bus.out_ovf   = out_ovf_reg;
`endif

  // Current nibble slice: 5-bit add with the chained carry, merged into the running sum.
  always_comb begin
    a_nib    = a_reg[{idx, 2'b00} +: 4];
    b_nib    = b_reg[{idx, 2'b00} +: 4];
    nib      = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    sum_next = sum_reg;
    sum_next[{idx, 2'b00} +: 4] = nib[3:0];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    // Carry into the nibble's top bit comes from the low three bits.
    low3     = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry};
    ovf_next = low3[3] ^ nib[4];
`endif
  end

  // Control FSM with all handshake/result outputs registered; reset abandons any in-flight add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      a_reg         <= {W{1'b0}};
      b_reg         <= {W{1'b0}};
      sum_reg       <= {W{1'b0}};
      carry         <= 1'b0;
      idx           <= {IDX_W{1'b0}};
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= {W{1'b0}};
      out_cout_reg  <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      out_ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg        <= bus.in_a;
            b_reg        <= bus.in_b;
            carry        <= bus.in_cin;
            idx          <= {IDX_W{1'b0}};
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state        <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum_reg <= sum_next;
          carry   <= nib[4];
          if (idx == LAST_IDX) begin
            out_sum_reg   <= sum_next;
            out_cout_reg  <= nib[4];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            out_ovf_reg   <= ovf_next;
`endif
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= RUN;
          end
        end
        DONE: begin
          // Result is held until downstream takes it; no new operands meanwhile.
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule
